rcp_header_writer: RTL and testbench
====================================

RCP_HEADER_WRITER -- requirements
Module: rcp_header_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning datapath width in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, meaning control width in bits.
REQ-003 SHALL have parameter RATE_WIDTH, default 32, meaning width of the RCP rate and RTT fields.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports in_data (input, DATA_WIDTH), in_ctrl (input, CTRL_WIDTH) and in_wr (input, 1), forming the upstream word stream.
REQ-007 SHALL have port in_rdy, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have ports out_data (output, DATA_WIDTH), out_ctrl (output, CTRL_WIDTH) and out_wr (output, 1), forming the downstream word stream.
REQ-009 SHALL have port out_rdy, input, 1, meaning downstream accepts a word.
REQ-010 SHALL have port local_rate, input, RATE_WIDTH, meaning the router's current fair rate.
REQ-011 SHALL have port rcp_en, input, 1, meaning rate stamping is enabled.
REQ-012 SHALL have ports rtt_sample (output, RATE_WIDTH) and rtt_valid (output, 1), meaning the captured packet RTT and its one-cycle strobe.
REQ-013 SHALL have port pkt_count, output, 16, meaning the count of packets whose rate field was lowered, wrapping at 16'hFFFF to 0.

Function
REQ-014 SHALL accept a word when in_wr && in_rdy, with in_rdy = !out_wr || out_rdy.
REQ-015 SHALL register each accepted word so that out_wr rises exactly one cycle after acceptance.
REQ-016 SHALL hold out_data, out_ctrl and out_wr stable while out_wr && !out_rdy.
REQ-017 SHALL implement a one-hot FSM with states HDRS, DATA and WAIT_EOP.
REQ-018 In HDRS, SHALL pass words with in_ctrl != 0 unchanged, and SHALL go to DATA with word index 0 on an accepted word with in_ctrl == 0.
REQ-019 In DATA, SHALL increment a 3-bit word index per accepted word; data word 0 is the first ctrl==0 word.
REQ-020 On data word 4, SHALL replace bits [63:32] with min(field, local_rate) when rcp_en is 1, and SHALL pass it unchanged when rcp_en is 0.
REQ-021 SHALL increment pkt_count when a replacement strictly lowers the field.
REQ-022 On data word 5, SHALL pass the word unchanged, load rtt_sample from bits [63:32], pulse rtt_valid for one cycle (same cycle as the word's out_wr rise), and go to WAIT_EOP.
REQ-023 In DATA or WAIT_EOP, an accepted word with in_ctrl != 0 (EOP) SHALL return the FSM to HDRS.
REQ-024 SHALL not rewrite or sample a packet that ends at word index < 4 (or < 5 for RTT), and SHALL not carry state into the next packet.
REQ-025 SHALL treat the rate compare as unsigned, with equal values meaning no change and no count.
REQ-026 SHALL pass in_ctrl through unmodified on every word.

Reset
REQ-027 On reset, SHALL set state to HDRS, word index 0, out_wr 0, out_data 0, out_ctrl 0, rtt_sample 0, rtt_valid 0 and pkt_count 0.
REQ-028 Reset mid-packet SHALL drop the in-flight word; words after deassertion SHALL be parsed from HDRS.

Structure
REQ-029 SHALL place the state encodings, the field word indices (4, 5) and the field bit offsets in shared package rcp_pkg, shared with the RCP parser.
REQ-030 SHALL instantiate one sub-module, rcp_rate_min, as combinational unsigned min plus a "lowered" flag; everything else is inline.

Verification
REQ-031 Stream 1 header word (ctrl FF) + 8 data words, word4[63:32]=1000, local_rate=600, rcp_en=1 -> out word4[63:32]=600, pkt_count=1, all other words bit-identical.
REQ-032 Same packet with local_rate=1500 -> word4 unchanged and pkt_count unchanged.
REQ-033 word5[63:32]=32'h0000_0ABC -> rtt_sample=0xABC and rtt_valid high for exactly 1 cycle.
REQ-034 A 4-data-word packet followed by a normal packet -> first packet unmodified, second packet rewritten at its own word 4.
REQ-035 Hold out_rdy=0 for 5 cycles mid-packet -> in_rdy=0 and output stable, with no word lost or duplicated.
REQ-036 Assert reset during data word 2, then send a full packet -> all outputs at reset values, and the new packet is rewritten correctly.

Source files
------------

// File: rtl/rcp_pkg.sv
// Shared RCP definitions: FSM encodings, field word indices and bit offsets
// used by the header writer and the RCP parser.
package rcp_pkg;

  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned FIELD_W    = 32;

  // One-hot parser states
  typedef enum logic [2:0] {
    HDRS     = 3'b001,
    DATA     = 3'b010,
    WAIT_EOP = 3'b100
  } rcp_state_e;

  localparam logic [WORD_IDX_W-1:0] RATE_WORD_IDX = 3'd4;
  localparam logic [WORD_IDX_W-1:0] RTT_WORD_IDX  = 3'd5;

  localparam int unsigned RATE_LSB = 32;
  localparam int unsigned RTT_LSB  = 32;

endpackage

// File: rtl/rcp_rate_min.sv
// Unsigned min of a packet rate field and the local rate, flagging when
// the local rate strictly lowers the field.
module rcp_rate_min #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_field,
  input  logic [WIDTH-1:0] i_limit,
  output logic [WIDTH-1:0] o_min_c,
  output logic             o_lowered_c
);

  assign o_lowered_c = (i_limit < i_field);
  assign o_min_c     = o_lowered_c ? i_limit : i_field;

endmodule

// File: rtl/rcp_header_writer.sv
// Registered word pipeline that stamps min(rate, local_rate) into data word 4
// and samples the RTT field from data word 5 of each packet.
module rcp_header_writer
  import rcp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned RATE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [RATE_WIDTH-1:0] local_rate,
  input  logic                  rcp_en,
  output logic [RATE_WIDTH-1:0] rtt_sample,
  output logic                  rtt_valid,
  output logic [15:0]           pkt_count
);

  rcp_state_e                r_state;
  rcp_state_e                w_state_next;
  logic [WORD_IDX_W-1:0]     r_word_idx;
  logic [WORD_IDX_W-1:0]     w_word_idx_next;
  logic [WORD_IDX_W-1:0]     w_cur_idx;

  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [CTRL_WIDTH-1:0]     r_out_ctrl;
  logic                      r_out_wr;
  logic [RATE_WIDTH-1:0]     r_rtt_sample;
  logic                      r_rtt_valid;
  logic [15:0]               r_pkt_count;

  logic                      w_accept;
  logic                      w_is_ctrl;
  logic                      w_rate_hit;
  logic                      w_rtt_hit;
  logic                      w_lowered;
  logic [RATE_WIDTH-1:0]     w_min_rate;
  logic [DATA_WIDTH-1:0]     w_data_next;

  assign in_rdy     = !r_out_wr || out_rdy;
  assign w_accept   = in_wr && in_rdy;
  assign w_is_ctrl  = (in_ctrl != '0);
  // r_word_idx holds the index of the last accepted data word
  assign w_cur_idx  = r_word_idx + 3'd1;

  assign out_data   = r_out_data;
  assign out_ctrl   = r_out_ctrl;
  assign out_wr     = r_out_wr;
  assign rtt_sample = r_rtt_sample;
  assign rtt_valid  = r_rtt_valid;
  assign pkt_count  = r_pkt_count;

  rcp_rate_min #(
    .WIDTH(RATE_WIDTH)
  ) u_rate_min (
    .i_field    (in_data[RATE_LSB +: RATE_WIDTH]),
    .i_limit    (local_rate),
    .o_min_c    (w_min_rate),
    .o_lowered_c(w_lowered)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HDRS;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word_idx <= w_word_idx_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_word_idx_next = r_word_idx;
    w_rate_hit      = 1'b0;
    w_rtt_hit       = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        HDRS: begin
          if (!w_is_ctrl) begin
            w_state_next    = DATA;
            w_word_idx_next = '0;
          end
        end
        DATA: begin
          w_word_idx_next = w_cur_idx;
          if (w_cur_idx == RATE_WORD_IDX) begin
            w_rate_hit = rcp_en;
          end
          if (w_cur_idx == RTT_WORD_IDX) begin
            w_rtt_hit    = 1'b1;
            w_state_next = WAIT_EOP;
          end
          // EOP wins over the WAIT_EOP transition
          if (w_is_ctrl) begin
            w_state_next    = HDRS;
            w_word_idx_next = '0;
          end
        end
        WAIT_EOP: begin
          if (w_is_ctrl) begin
            w_state_next    = HDRS;
            w_word_idx_next = '0;
          end
        end
        default: begin
          w_state_next    = HDRS;
          w_word_idx_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_data_next = in_data;
    if (w_rate_hit) begin
      w_data_next[RATE_LSB +: RATE_WIDTH] = w_min_rate;
    end
  end

  // Output skid register, RTT capture and lowered-rate counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_out_wr     <= 1'b0;
      r_rtt_sample <= '0;
      r_rtt_valid  <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      r_rtt_valid <= 1'b0;
      if (w_accept) begin
        r_out_data <= w_data_next;
        r_out_ctrl <= in_ctrl;
        r_out_wr   <= 1'b1;
      end else if (out_rdy) begin
        r_out_wr <= 1'b0;
      end
      if (w_rtt_hit) begin
        r_rtt_sample <= in_data[RTT_LSB +: RATE_WIDTH];
        r_rtt_valid  <= 1'b1;
      end
      if (w_rate_hit && w_lowered) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rcp_header_writer.sv
// Randomized bench for rcp_header_writer: packet-level reference model plus
// a per-cycle compare process and directed literal checks.
module tb_rcp_header_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [31:0] local_rate;
  logic        rcp_en;
  logic [31:0] rtt_sample;
  logic        rtt_valid;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  rcp_header_writer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .local_rate(local_rate),
    .rcp_en    (rcp_en),
    .rtt_sample(rtt_sample),
    .rtt_valid (rtt_valid),
    .pkt_count (pkt_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Word accepted at the coming edge and what the model says it must become
  logic        tb_acc      = 1'b0;
  logic [63:0] tb_exp_data = '0;
  logic [7:0]  tb_exp_ctrl = '0;
  logic        tb_w4       = 1'b0;
  logic        tb_rtt      = 1'b0;
  logic        tb_lower    = 1'b0;

  int   force_stall = 0;
  logic rand_bp     = 1'b0;

  logic        m_out_wr;
  logic [63:0] m_data;
  logic [7:0]  m_ctrl;
  logic [31:0] m_rtt;
  logic [15:0] m_cnt;
  logic [31:0] cap_w4 = '0;
  int          rtt_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: advance the model by the edge just taken, then check
  initial begin
    m_out_wr = 1'b0; m_data = '0; m_ctrl = '0; m_rtt = '0; m_cnt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_out_wr = 1'b0; m_data = '0; m_ctrl = '0; m_rtt = '0; m_cnt = '0;
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_rtt_valid", 64'(rtt_valid), 64'd0);
      end else begin
        if (tb_acc) begin
          m_out_wr = 1'b1;
          m_data   = tb_exp_data;
          m_ctrl   = tb_exp_ctrl;
          if (tb_rtt)   m_rtt = tb_exp_data[63:32];
          if (tb_lower) m_cnt = m_cnt + 16'd1;
          if (tb_w4)    cap_w4 = out_data[63:32];
        end else if (out_rdy) begin
          m_out_wr = 1'b0;
        end
        if (rtt_valid) rtt_pulses++;
        check("rtt_valid", 64'(rtt_valid), 64'(tb_acc && tb_rtt));
        if (m_out_wr) begin
          check("out_data", out_data, m_data);
          check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        end
        if (out_wr && !out_rdy) check("stall_in_rdy", 64'(in_rdy), 64'd0);
      end
      check("out_wr", 64'(out_wr), 64'(m_out_wr));
      check("in_rdy", 64'(in_rdy), 64'(!m_out_wr || out_rdy));
      check("rtt_sample", 64'(rtt_sample), 64'(m_rtt));
      check("pkt_count", 64'(pkt_count), 64'(m_cnt));
    end
  end

  task automatic drive(input logic wr, input logic [63:0] d, input logic [7:0] c,
                       input logic [63:0] ed, input logic w4, input logic rt,
                       input logic lw, output logic acc);
    @(negedge clk);
    if (force_stall > 0) begin
      out_rdy = 1'b0;
      force_stall--;
    end else begin
      out_rdy = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    in_wr = wr; in_data = d; in_ctrl = c;
    tb_exp_data = ed; tb_exp_ctrl = c; tb_w4 = w4; tb_rtt = rt; tb_lower = lw;
    #1;
    acc    = wr && in_rdy;
    tb_acc = acc;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic cfg(input logic en, input logic [31:0] rate);
    @(posedge clk);
    #2;
    rcp_en     = en;
    local_rate = rate;
  endtask

  // Packet = nh header words (ctrl FF) then nd data words, the last one EOP
  task automatic send_pkt(input int nh, input int nd, input logic [31:0] f4,
                          input logic [31:0] f5, input int reset_after,
                          input int stall_after);
    for (int k = 0; k < nh + nd; k++) begin
      logic [63:0] d, ed;
      logic [7:0]  c;
      logic        w4, rt, lw, acc, gap;
      int          j, tries;
      j  = k - nh;
      d  = {$urandom, $urandom};
      c  = 8'hFF;
      if (j >= 0) begin
        c = (j == nd - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        if (j == 4) d[63:32] = f4;
        if (j == 5) d[63:32] = f5;
      end
      ed = d;
      w4 = (j == 4);
      rt = (j == 5);
      lw = 1'b0;
      if (w4 && rcp_en && (f4 > local_rate)) begin
        ed[63:32] = local_rate;
        lw        = 1'b1;
      end
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 200) begin
        gap = rand_bp && ($urandom_range(0, 3) == 0);
        drive(!gap, d, c, ed, w4, rt, lw, acc);
        tries++;
      end
      if (!acc) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: word %0d not accepted within 200 cycles", k);
        return;
      end
      if (k == stall_after) force_stall = 5;
      if (k == reset_after) begin
        @(negedge clk);
        in_wr  = 1'b0;
        tb_acc = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    out_rdy = 1'b1; rcp_en = 1'b0; local_rate = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Rate lowered 1000 -> 600
    cfg(1'b1, 32'd600);
    send_pkt(1, 8, 32'd1000, 32'h55, -1, -1);
    idle(4);
    check("p1_word4", 64'(cap_w4), 64'd600);
    check("p1_count", 64'(pkt_count), 64'd1);

    // Local rate above field: untouched
    cfg(1'b1, 32'd1500);
    send_pkt(1, 8, 32'd1000, 32'h66, -1, -1);
    idle(4);
    check("p2_word4", 64'(cap_w4), 64'd1000);
    check("p2_count", 64'(pkt_count), 64'd1);

    // RTT capture with single pulse
    begin
      int p0;
      p0 = rtt_pulses;
      send_pkt(1, 8, 32'd500, 32'h0000_0ABC, -1, -1);
      idle(4);
      check("rtt_value", 64'(rtt_sample), 64'hABC);
      check("rtt_pulses", 64'(rtt_pulses - p0), 64'd1);
    end

    // Short packet untouched, next packet rewritten at its own word 4
    cfg(1'b1, 32'd600);
    cap_w4 = 32'hDEAD_BEEF;
    send_pkt(1, 4, 32'd1000, 32'h1, -1, -1);
    idle(3);
    check("short_word4", 64'(cap_w4), 64'hDEAD_BEEF);
    check("short_count", 64'(pkt_count), 64'd1);
    send_pkt(2, 8, 32'd1000, 32'h2, -1, -1);
    idle(4);
    check("after_short_word4", 64'(cap_w4), 64'd600);
    check("after_short_count", 64'(pkt_count), 64'd2);

    // Equal rate: no change, no count
    cfg(1'b1, 32'd1000);
    send_pkt(1, 7, 32'd1000, 32'h3, -1, -1);
    idle(4);
    check("equal_word4", 64'(cap_w4), 64'd1000);
    check("equal_count", 64'(pkt_count), 64'd2);

    // Five-cycle downstream stall mid-packet
    cfg(1'b1, 32'd600);
    send_pkt(1, 8, 32'd700, 32'h4, -1, 3);
    idle(4);
    check("stall_word4", 64'(cap_w4), 64'd600);
    check("stall_count", 64'(pkt_count), 64'd3);

    // Reset during data word 2, then a clean packet
    send_pkt(1, 8, 32'd1000, 32'h5, 1 + 2, -1);
    check("post_rst_count", 64'(pkt_count), 64'd0);
    check("post_rst_out_wr", 64'(out_wr), 64'd0);
    check("post_rst_rtt", 64'(rtt_sample), 64'd0);
    send_pkt(1, 8, 32'd900, 32'h6, -1, -1);
    idle(4);
    check("post_rst_word4", 64'(cap_w4), 64'd600);
    check("post_rst_count2", 64'(pkt_count), 64'd1);

    // Randomized traffic with backpressure and input gaps
    rand_bp = 1'b1;
    for (int p = 0; p < 60; p++) begin
      cfg(1'($urandom_range(0, 1)), 32'($urandom_range(0, 20)));
      send_pkt($urandom_range(1, 3), $urandom_range(2, 10),
               32'($urandom_range(0, 20)), $urandom, -1, -1);
    end
    rand_bp = 1'b0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
